// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers for the execute stage. Runs mult/multu/div/divu (and
//            optionally msub) over a fixed number of cycles and performs
//            mthi/mtlo in a single cycle. Exposes a busy flag for the hazard
//            unit.
// Build    : MULDIV_MSUB_EN  - when defined, ctrl code 7 performs
//                              {HI,LO} <= {HI,LO} - signed(a*b).
//                              When undefined, code 7 is a no-op and the
//                              msub datapath is not built.
// Params   : MUL_CYCLES  busy cycles for mult/multu/msub (1..31)
//            DIV_CYCLES  busy cycles for div/divu        (1..31)
// Ports    : clk        in   clock, rising edge active
//            reset      in   asynchronous, active-low reset
//            ctrl[2:0]  in   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,
//                            6 mtlo,7 msub; sampled only while busy=0
//            a[31:0]    in   rs operand (dividend / multiplicand / mtXX src)
//            b[31:0]    in   rt operand (divisor / multiplier)
//            outputSel  in   1 selects HI, 0 selects LO on out
//            busy       out  multi-cycle operation in flight
//            out[31:0]  out  committed HI or LO (combinational from sel)
// Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        outputSel,
  output logic        busy,
  output logic [31:0] out
);

  // --------------------------------------------------------------------------
  // Operation codes
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_NONE  = 3'd0;
  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;
  localparam logic [2:0] c_OP_MSUB  = 3'd7;

  localparam logic [4:0] c_MUL_CNT = 5'(MUL_CYCLES);
  localparam logic [4:0] c_DIV_CNT = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  // --------------------------------------------------------------------------
  // Command decode. Without msub support code 7 collapses to "no operation"
  // so it can never start a busy period or touch HI/LO.
  // --------------------------------------------------------------------------
  logic [2:0] ctrl_eff;
  logic       accept;
  logic       is_div_cmd;

`ifdef MULDIV_MSUB_EN
  assign ctrl_eff = ctrl;
`else
  assign ctrl_eff = (ctrl == c_OP_MSUB) ? c_OP_NONE : ctrl;
`endif

  assign accept     = (state_q == S_IDLE) && (ctrl_eff != c_OP_NONE);
  assign is_div_cmd = (ctrl_eff == c_OP_DIV) || (ctrl_eff == c_OP_DIVU);

  // --------------------------------------------------------------------------
  // Multiply datapath, fed from the operands latched at the accept edge.
  // --------------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
  assign prod_u = {32'd0, opa_q} * {32'd0, opb_q};

  // --------------------------------------------------------------------------
  // Divide datapath. Signed division runs on magnitudes and re-applies the
  // signs afterwards: this yields truncation toward zero, a remainder with the
  // dividend's sign, and makes 0x80000000 / -1 fall out as 0x80000000 rem 0
  // without a special case (|0x80000000| is representable unsigned).
  // --------------------------------------------------------------------------
  logic        div_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot_d;
  logic [31:0] rem_d;

  assign div_signed = (op_q == c_OP_DIV);
  assign neg_a      = div_signed & opa_q[31];
  assign neg_b      = div_signed & opb_q[31];
  assign mag_a      = neg_a ? (32'd0 - opa_q) : opa_q;
  assign mag_b      = neg_b ? (32'd0 - opb_q) : opb_q;
  // Keep the divider free of a zero divisor; the zero case is overridden below.
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / mag_b_safe;
  assign r_mag      = mag_a % mag_b_safe;

  always_comb begin
    quot_d = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem_d  = neg_a ? (32'd0 - r_mag) : r_mag;
    if (opb_q == 32'd0) begin
      quot_d = 32'hFFFF_FFFF;
      rem_d  = opa_q;
    end
  end

  // --------------------------------------------------------------------------
  // Multiply-subtract. HI/LO cannot change while busy (except via reset), so
  // using the live registers here equals the value at commit.
  // --------------------------------------------------------------------------
`ifdef MULDIV_MSUB_EN
  logic [63:0] msub_d;
  assign msub_d = {hi_q, lo_q} - prod_s;
`endif

  // --------------------------------------------------------------------------
  // Result selection for the commit edge
  // --------------------------------------------------------------------------
  logic [63:0] result_d;

  always_comb begin
    result_d = {hi_q, lo_q};
    case (op_q)
      c_OP_MULT:  result_d = prod_s;
      c_OP_MULTU: result_d = prod_u;
      c_OP_DIV:   result_d = {rem_d, quot_d};
      c_OP_DIVU:  result_d = {rem_d, quot_d};
`ifdef MULDIV_MSUB_EN
      c_OP_MSUB:  result_d = msub_d;
`endif
      default:    result_d = {hi_q, lo_q};
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM and architectural registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= c_OP_NONE;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (ctrl_eff)
              c_OP_MTHI: hi_q <= a;
              c_OP_MTLO: lo_q <= a;
              default: begin
                op_q    <= ctrl_eff;
                opa_q   <= a;
                opb_q   <= b;
                cnt_q   <= is_div_cmd ? c_DIV_CNT : c_MUL_CNT;
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          // Commands arriving here are ignored; the counter alone decides
          // when the in-flight result lands.
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            hi_q    <= result_d[63:32];
            lo_q    <= result_d[31:0];
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign out  = outputSel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit. Expected values
//            are hand-computed constants. Honours MULDIV_MSUB_EN the same way
//            the design does.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        outputSel;
  logic        busy;
  logic [31:0] out;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .a         (a),
    .b         (b),
    .outputSel (outputSel),
    .busy      (busy),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    outputSel = 1'b1;
    #1 hi = out;
    outputSel = 1'b0;
    #1 lo = out;
  endtask

  // Issue a command for one edge, then count cycles with busy=1 (bounded).
  task automatic run_op(input logic [2:0] c, input logic [31:0] aa,
                        input logic [31:0] bb, output int cnt);
    ctrl = c;
    a    = aa;
    b    = bb;
    step();
    ctrl = 3'd0;
    cnt  = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      step();
    end
  endtask

  logic [31:0] hi;
  logic [31:0] lo;
  int          n;
  logic        busy_seen;

  initial begin
    reset     = 1'b0;
    ctrl      = 3'd0;
    a         = 32'd0;
    b         = 32'd0;
    outputSel = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    step();

    // ---------------- mthi / mtlo ----------------
    busy_seen = 1'b0;
    ctrl = 3'd5; a = 32'h1234_5678;
    step();
    busy_seen |= busy;
    ctrl = 3'd6; a = 32'h9ABC_DEF0;
    step();
    busy_seen |= busy;
    ctrl = 3'd0;
    step();
    busy_seen |= busy;
    chk("mtxx_busy", {31'd0, busy_seen}, 32'd0);
    read_hilo(hi, lo);
    chk("mthi_out", hi, 32'h1234_5678);
    chk("mtlo_out", lo, 32'h9ABC_DEF0);

    // ---------------- mult (-2 * 3), old value visible while busy ----------
    ctrl = 3'd1; a = 32'hFFFF_FFFE; b = 32'd3;
    step();
    ctrl = 3'd0;
    outputSel = 1'b0;
    #1 chk("mult_busy_holds_lo", out, 32'h9ABC_DEF0);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    chk("mult_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // ---------------- multu ----------------
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, n);
    chk("multu_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // ---------------- div -7 / 2 ----------------
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, 32'd10);
    read_hilo(hi, lo);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // ---------------- div by zero ----------------
    run_op(3'd3, 32'd5, 32'd0, n);
    read_hilo(hi, lo);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    // ---------------- div overflow ----------------
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    read_hilo(hi, lo);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // ---------------- divu ----------------
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, n);
    chk("divu_cycles", n, 32'd10);
    read_hilo(hi, lo);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'd1);

    run_op(3'd4, 32'h0000_1234, 32'd0, n);
    read_hilo(hi, lo);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_1234);

    // ---------------- msub ----------------
    ctrl = 3'd5; a = 32'd0;
    step();
    ctrl = 3'd6; a = 32'd10;
    step();
    ctrl = 3'd0;
    run_op(3'd7, 32'd3, 32'd4, n);
    read_hilo(hi, lo);
`ifdef MULDIV_MSUB_EN
    chk("msub_cycles", n, 32'd5);
    chk("msub_hi", hi, 32'hFFFF_FFFF);
    chk("msub_lo", lo, 32'hFFFF_FFFE);
`else
    chk("msub_off_cycles", n, 32'd0);
    chk("msub_off_hi", hi, 32'd0);
    chk("msub_off_lo", lo, 32'd10);
`endif

    // ---------------- command while busy is ignored ----------------
    ctrl = 3'd2; a = 32'd2; b = 32'd3;
    step();                         // accept edge T0
    ctrl = 3'd0;
    step();                         // T0+1
    ctrl = 3'd6; a = 32'h55;
    step();                         // T0+2: mtlo must be dropped
    ctrl = 3'd0;
    n = 2;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    chk("ignore_cycles", n, 32'd5);
    read_hilo(hi, lo);
    chk("ignore_lo", lo, 32'd6);
    chk("ignore_hi", hi, 32'd0);

    // ---------------- reset mid-divide ----------------
    ctrl = 3'd4; a = 32'd100; b = 32'd7;
    step();
    ctrl = 3'd0;
    step();
    step();
    chk("middiv_busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1 chk("rst_async_busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    chk("rst_async_hi", hi, 32'd0);
    chk("rst_async_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      busy_seen |= busy;
    end
    chk("rst_no_busy", {31'd0, busy_seen}, 32'd0);
    read_hilo(hi, lo);
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_no_commit_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
